// File: rtl/fixed_divider.sv
// fixed_divider: sequential sign-magnitude fixed-point divider, result = a / b.
// Number format is Q(intbits).(fracbits) sign-magnitude, matching the fixed-point
// multiplier. Restoring radix-2 division, one quotient bit per clock.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b captured when both high)
//   a, b                  dividend / divisor, sign-magnitude, n bits
//   out_valid / out_ready result handshake
//   result                quotient, sign-magnitude, magnitude truncated toward zero
//   ovf                   quotient magnitude overflowed n-1 bits (also set on divide-by-zero)
//   dz                    divisor magnitude was zero
module fixed_divider #(
  parameter int n        = 32,
  parameter int intbits  = 12,
  parameter int fracbits = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] result,
  output logic         ovf,
  output logic         dz
);

  // Quotient width: magnitude (n-1 bits) pre-scaled by 2^fracbits.
  // intbits + fracbits == n, so this equals n-1+fracbits.
  localparam int QW = intbits + 2 * fracbits - 1;
  localparam int CW = $clog2(n + fracbits);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nx;
  logic [QW-1:0] dq;      // dividend bits shift out of the MSB, quotient bits shift into the LSB
  logic [n-1:0]  rem;
  logic [n-2:0]  dvs;
  logic          sgn;
  logic [CW-1:0] cnt;
  logic [n-1:0]  res_q;
  logic          ovf_q, dz_q;

  logic [n:0]    trial;
  logic          ge;
  logic [n-1:0]  diff;
  logic [QW-1:0] q_nx;
  logic          last;
  logic          b_zero;

  // rem < dvs < 2^(n-1) always holds, so the subtraction fits in n bits.
  always_comb begin
    trial  = {rem, dq[QW-1]};
    ge     = trial >= {2'b00, dvs};
    diff   = trial[n-1:0] - {1'b0, dvs};
    q_nx   = {dq[QW-2:0], ge};
    last   = cnt == CW'(QW - 1);
    b_zero = b[n-2:0] == '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = b_zero ? DONE : CALC;
      CALC:    if (last)     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      sgn   <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn <= a[n-1] ^ b[n-1];
          dq  <= {a[n-2:0], {fracbits{1'b0}}};
          dvs <= b[n-2:0];
          rem <= '0;
          cnt <= '0;
          // Divide-by-zero skips CALC; its result is loaded directly.
          if (b_zero) begin
            res_q <= {a[n-1] ^ b[n-1], {(n-1){1'b1}}};
            ovf_q <= 1'b1;
            dz_q  <= 1'b1;
          end
        end
        CALC: begin
          dq  <= q_nx;
          rem <= ge ? diff : trial[n-1:0];
          cnt <= cnt + 1'b1;
          // On overflow the low bits wrap; ovf flags any lost high quotient bit.
          if (last) begin
            res_q <= {sgn, q_nx[n-2:0]};
            ovf_q <= |q_nx[QW-1:n-1];
            dz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    result    = res_q;
    ovf       = ovf_q;
    dz        = dz_q;
  end

endmodule

// File: tb/tb_fixed_divider.sv
// tb_fixed_divider: directed + random checks of fixed_divider against a scoreboard
// of expected results (quotient, flags, latency in edges counted from the accepting edge).
module tb_fixed_divider;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready, out_valid, ovf, dz;
  logic [N-1:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  fixed_divider #(.n(32), .intbits(12), .fracbits(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic o, input logic z, input logic [7:0] l);
    exp_t e;
    e.res = r; e.ovf = o; e.dz = z; e.lat = l;
    return e;
  endfunction

  // Arithmetic reference: magnitude of (a * 2^20) / b, truncated.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb);
    logic [63:0] num, q;
    logic        s;
    s = ta[31] ^ tb[31];
    if (tb[30:0] == 31'd0) return mk({s, 31'h7FFFFFFF}, 1'b1, 1'b1, 8'd1);
    num = {33'd0, ta[30:0]} << 20;
    q   = num / {33'd0, tb[30:0]};
    return mk({s, q[30:0]}, |q[63:31], 1'b0, 8'd52);
  endfunction

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input exp_t e);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;   // operand changes after capture must not matter
  endtask

  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_lat"}, 64'(lat), {56'd0, e.lat});
    chk({tag, "_result"}, {32'd0, result}, {32'd0, e.res});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
    chk({tag, "_dz"}, {63'd0, dz}, {63'd0, e.dz});
    chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_ret_idle"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_ret_nvalid"}, {63'd0, out_valid}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {62'd0, ovf, dz}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic quotients
    issue(32'h00300000, 32'h00200000, mk(32'h00180000, 1'b0, 1'b0, 8'd52));
    collect("div_3_2");
    issue(32'h80300000, 32'h00200000, mk(32'h80180000, 1'b0, 1'b0, 8'd52));
    collect("div_m3_2");
    issue(32'h00100000, 32'h00300000, mk(32'h00055555, 1'b0, 1'b0, 8'd52));
    collect("div_1_3");
    // Quotient overflow wraps
    issue(32'h7FF00000, 32'h00000001, mk(32'h00000000, 1'b1, 1'b0, 8'd52));
    collect("div_ovf");
    // Divide-by-zero with "-0" divisor
    issue(32'h00100000, 32'h80000000, mk(32'hFFFFFFFF, 1'b1, 1'b1, 8'd1));
    collect("div_dz");
    // Negative zero quotient
    issue(32'h00000000, 32'h80100000, mk(32'h80000000, 1'b0, 1'b0, 8'd52));
    collect("div_negzero");

    // Random operands against the arithmetic reference
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i < 2) ? $urandom : 32'($urandom_range(1, 255)) | (32'($urandom_range(0, 1)) << 31);
      issue(ra, rb, model(ra, rb));
      collect("div_rand");
    end

    // Back-pressure: outputs hold, in_valid ignored
    out_ready = 1'b0;
    issue(32'h00300000, 32'h00200000, mk(32'h00180000, 1'b0, 1'b0, 8'd52));
    collect("div_hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = $urandom; b = $urandom;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_result", {32'd0, result}, 64'h00180000);
      chk("hold_flags", {62'd0, ovf, dz}, 64'd0);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("idle_no_phantom", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    a = 32'h00300000; b = 32'h00200000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h00300000, 32'h00200000, mk(32'h00180000, 1'b0, 1'b0, 8'd52));
    collect("div_after_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
